// File: rtl/fp_add_scheduler.sv
// fp_add_scheduler
// Round-robin front end for a single shared floating-point add/sub unit.
// One operation is in flight at a time: accept, start the unit, wait for
// done (bounded by a watchdog), then return result/status to the winner.
module fp_add_scheduler #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clock_100kHz,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [32*N_REQ-1:0]    req_op_a,
    input  logic [32*N_REQ-1:0]    req_op_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [31:0]            rsp_data,
    output logic [3:0]             rsp_status,
    output logic [31:0]            fpu_op_a,
    output logic [31:0]            fpu_op_b,
    output logic                   fpu_start,
    input  logic                   fpu_done,
    input  logic [31:0]            fpu_data,
    input  logic [3:0]             fpu_status,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       ST_TIMEOUT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_grant;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_rsp_data;
    logic [3:0]         r_rsp_status;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_timeout_err;

    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic [IDX_W-1:0]   w_cand;
    logic               w_accept;
    logic               w_rsp_take;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_last_grant;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_cand = IDX_W'((int'(r_last_grant) + k) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_accept   = (r_state == S_IDLE) && w_found;
    assign w_rsp_take = rsp_ready[r_grant];

    // Accept strobe: only in IDLE, and forced low while reset is held.
    always_comb begin
        req_ready = '0;
        if (w_accept && !reset) begin
            req_ready[w_win] = 1'b1;
        end
    end

    // Response valid goes only to the requester that owns the operation.
    always_comb begin
        rsp_valid = '0;
        if (r_state == S_RESPOND) begin
            rsp_valid[r_grant] = 1'b1;
        end
    end

    assign fpu_start   = (r_state == S_ISSUE);
    assign busy        = (r_state != S_IDLE);
    assign fpu_op_a    = r_op_a;
    assign fpu_op_b    = r_op_b;
    assign rsp_data    = r_rsp_data;
    assign rsp_status  = r_rsp_status;
    assign timeout_err = r_timeout_err;

    // State register.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; done beats the watchdog when both fire together.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_state_nxt = S_ISSUE;
            S_ISSUE:   w_state_nxt = S_WAIT;
            S_WAIT:    if (fpu_done || (r_cnt == CNT_LAST)) w_state_nxt = S_RESPOND;
            S_RESPOND: if (w_rsp_take) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, watchdog, result capture and grant history.
    always_ff @(posedge clock_100kHz or posedge reset) begin
        if (reset) begin
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_grant       <= '0;
            r_last_grant  <= LAST_RST;
            r_rsp_data    <= '0;
            r_rsp_status  <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op_a  <= req_op_a[int'(w_win)*32 +: 32];
                        r_op_b  <= req_op_b[int'(w_win)*32 +: 32];
                        r_grant <= w_win;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (fpu_done) begin
                        r_rsp_data   <= fpu_data;
                        r_rsp_status <= fpu_status;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data    <= '0;
                        r_rsp_status  <= ST_TIMEOUT;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESPOND: begin
                    if (w_rsp_take) begin
                        r_last_grant <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Directed bench for fp_add_scheduler with a small behavioural FP unit.
module tb_fp_add_scheduler;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_op_a;
    logic [127:0] req_op_b;
    logic [3:0]   req_ready;
    logic [3:0]   rsp_valid;
    logic [3:0]   rsp_ready;
    logic [31:0]  rsp_data;
    logic [3:0]   rsp_status;
    logic [31:0]  fpu_op_a;
    logic [31:0]  fpu_op_b;
    logic         fpu_start;
    logic         fpu_done;
    logic [31:0]  fpu_data;
    logic [3:0]   fpu_status;
    logic         busy;
    logic         timeout_err;

    logic         mdl_done;
    logic         tb_done;
    int           mdl_delay;
    logic [31:0]  mdl_data;
    logic [3:0]   mdl_stat;

    int n_checks = 0;
    int n_pass   = 0;

    assign fpu_done = mdl_done | tb_done;

    fp_add_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .clock_100kHz (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_op_a     (req_op_a),
        .req_op_b     (req_op_b),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_status   (rsp_status),
        .fpu_op_a     (fpu_op_a),
        .fpu_op_b     (fpu_op_b),
        .fpu_start    (fpu_start),
        .fpu_done     (fpu_done),
        .fpu_data     (fpu_data),
        .fpu_status   (fpu_status),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FP unit: done mdl_delay WAIT cycles after start (0 = never).
    initial begin
        int  cnt;
        bit  pend;
        cnt = 0;
        pend = 0;
        mdl_done = 1'b0;
        fpu_data = 32'hDEAD_BEEF;
        fpu_status = 4'h7;
        forever begin
            @(posedge clk);
            #1;
            mdl_done = 1'b0;
            fpu_data = 32'hDEAD_BEEF;
            fpu_status = 4'h7;
            if (pend) begin
                if (cnt == 0) begin
                    mdl_done = 1'b1;
                    fpu_data = mdl_data;
                    fpu_status = mdl_stat;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
            if (fpu_start && mdl_delay > 0) begin
                pend = 1;
                cnt = mdl_delay - 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000ns");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == 4'b0000 && n < 200) begin
            tick();
            n++;
        end
    endtask

    function automatic int oh2i(input logic [3:0] v);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic run_op(input string tag, input logic [3:0] vld, input logic [3:0] exp_g);
        int n;
        req_valid = vld;
        #1;
        chk({tag, "_ready"}, {28'd0, req_ready}, {28'd0, exp_g});
        tick();
        req_valid = 4'b0000;
        wait_rsp(n);
        chk({tag, "_rsp_valid"}, {28'd0, rsp_valid}, {28'd0, exp_g});
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = 4'b0000;
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int starts;
        int readies;
        int bad;
        int n_g;
        int grants[5];
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        req_valid = '0;
        req_op_a = '0;
        req_op_b = '0;
        rsp_ready = '0;
        tb_done = 1'b0;
        mdl_delay = 0;
        mdl_data = '0;
        mdl_stat = '0;
        tick();
        tick();

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
        chk("rst_start", {31'd0, fpu_start}, 32'd0);
        chk("rst_op_a", fpu_op_a, 32'd0);
        chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single request, done after 5 WAIT cycles
        mdl_delay = 5;
        mdl_data = 32'h08A0_0000;
        mdl_stat = 4'h0;
        req_op_a[31:0] = 32'h0880_0000;
        req_op_b[31:0] = 32'h0840_0000;
        req_valid = 4'b0001;
        #1;
        chk("t1_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        chk("t1_op_a", fpu_op_a, 32'h0880_0000);
        chk("t1_op_b", fpu_op_b, 32'h0840_0000);
        starts = 0;
        readies = 0;
        n = 0;
        while (rsp_valid == 4'b0000 && n < 200) begin
            if (fpu_start) starts++;
            if (req_ready != 4'b0000) readies++;
            tick();
            n++;
        end
        chk("t1_latency", n, 32'd6);
        chk("t1_starts", starts, 32'd1);
        chk("t1_extra_ready", readies, 32'd0);
        chk("t1_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        chk("t1_data", rsp_data, 32'h08A0_0000);
        chk("t1_status", {28'd0, rsp_status}, 32'h0);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        chk("t1_idle", {31'd0, busy}, 32'd0);
        chk("t1_op_hold", fpu_op_a, 32'h0880_0000);

        // 2: all requesting, fresh priority -> 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_delay = 1;
        mdl_data = 32'h1234_5678;
        mdl_stat = 4'h3;
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        n_g = 0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) bad++;
            if (req_ready != 4'b0000 && n_g < 5) begin
                grants[n_g] = oh2i(req_ready);
                n_g++;
            end
            tick();
            if (n_g == 5) begin
                req_valid = 4'b0000;
                break;
            end
        end
        n = 0;
        while (busy && n < 50) begin
            if (!$onehot0(req_ready) || !$onehot0(rsp_valid)) bad++;
            tick();
            n++;
        end
        rsp_ready = 4'b0000;
        chk("t2_n_grants", n_g, 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2_grant%0d", i), grants[i], exp_order[i]);
        end
        chk("t2_onehot", bad, 32'd0);
        chk("t2_idle", {31'd0, busy}, 32'd0);

        // 3: last_grant=1, requests 1 and 3 -> 3 wins
        run_op("t3_setup", 4'b0010, 4'b0010);
        run_op("t3", 4'b1010, 4'b1000);

        // 4: watchdog timeout, later done ignored
        mdl_delay = 0;
        req_valid = 4'b0001;
        #1;
        chk("t4_ready", {28'd0, req_ready}, 32'h1);
        tick();
        req_valid = 4'b0000;
        wait_rsp(n);
        chk("t4_latency", n, 32'd65);
        chk("t4_rsp_valid", {28'd0, rsp_valid}, 32'h1);
        chk("t4_data", rsp_data, 32'd0);
        chk("t4_status", {28'd0, rsp_status}, 32'hF);
        chk("t4_tmo", {31'd0, timeout_err}, 32'd1);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = 4'b0000;
        tick();
        tick();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        #1;
        chk("t4_late_busy", {31'd0, busy}, 32'd0);
        chk("t4_late_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("t4_late_status", {28'd0, rsp_status}, 32'hF);
        chk("t4_tmo_sticky", {31'd0, timeout_err}, 32'd1);

        // 5: response back-pressure for 10 cycles
        mdl_delay = 2;
        mdl_data = 32'h3F80_0001;
        mdl_stat = 4'h3;
        req_valid = 4'b0100;
        #1;
        chk("t5_ready", {28'd0, req_ready}, 32'h4);
        tick();
        req_valid = 4'b1011;
        rsp_ready = 4'b1011;
        wait_rsp(n);
        chk("t5_rsp_valid", {28'd0, rsp_valid}, 32'h4);
        chk("t5_data", rsp_data, 32'h3F80_0001);
        chk("t5_status", {28'd0, rsp_status}, 32'h3);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (rsp_valid != 4'b0100 || rsp_data != 32'h3F80_0001 ||
                rsp_status != 4'h3 || req_ready != 4'b0000) bad++;
        end
        chk("t5_stable", bad, 32'd0);
        req_valid = 4'b0000;
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = 4'b0000;
        #1;
        chk("t5_idle", {31'd0, busy}, 32'd0);

        // 6: reset during WAIT aborts; stale done ignored; priority restarts at 0
        mdl_delay = 6;
        mdl_data = 32'h5555_AAAA;
        req_valid = 4'b1000;
        #1;
        chk("t6_ready", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        chk("t6_busy_wait", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_start", {31'd0, fpu_start}, 32'd0);
        chk("t6_rst_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("t6_rst_op_a", fpu_op_a, 32'd0);
        chk("t6_rst_data", rsp_data, 32'd0);
        chk("t6_rst_status", {28'd0, rsp_status}, 32'd0);
        chk("t6_rst_tmo", {31'd0, timeout_err}, 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("t6_stale_busy", {31'd0, busy}, 32'd0);
        chk("t6_stale_rsp", {28'd0, rsp_valid}, 32'd0);
        chk("t6_stale_data", rsp_data, 32'd0);
        mdl_delay = 1;
        run_op("t6_after", 4'b1001, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
